uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one UART byte transmitter among N byte-stream requesters. Each requester presents a byte, a per-port baud code and a last-of-packet flag. The scheduler grants one port and latches that port's byte. It programs the transmitter's baud code, fires a one-cycle send strobe and waits for transmit-done. It sits between the on-chip message sources and the single RS-232 byte transmitter.

---
 rtl/uart_tx_scheduler.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Round-robin arbiter sharing one UART byte transmitter among N requesters.
//   A granted port's byte/baud/last are latched in GRANT, the transmitter gets
//   one SETUP cycle for its baud divisor, a one-cycle send strobe, then the
//   scheduler waits for tx_done (or a timeout) and idles GAP_CYC clocks.
//   Packets (last=0 bytes) keep the transmitter locked to their owner.
// Ports:
//   Clk, Rst_n          clock, async active-low reset
//   req/req_data/req_baud/req_last   per-port byte request (packed by port)
//   ack                 one-cycle pulse: port's byte latched, next may follow
//   grant               one-hot owner, zero in IDLE
//   tx_data_byte/tx_baud_set/tx_send_en   transmitter command
//   tx_done             transmitter done pulse (honoured only in WAIT)
//   busy                high outside IDLE
//   err_timeout         one-cycle pulse when a byte is aborted
module uart_tx_scheduler #(
  parameter int N           = 4,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  input  logic [3*N-1:0] req_baud,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   grant,
  output logic [7:0]     tx_data_byte,
  output logic [2:0]     tx_baud_set,
  output logic           tx_send_en,
  input  logic           tx_done,
  output logic           busy,
  output logic           err_timeout
);
  // One counter serves both the WAIT timeout and the GAP count, so it is
  // sized for whichever limit is larger.
  localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_SETUP, S_SEND, S_WAIT, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [7:0]    data_q, data_d;
  logic [2:0]    baud_q, baud_d;
  logic          lock_q, lock_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [PW-1:0] winner;
  logic          found;
  int            idx;

  logic timeout_hit, gap_done;
  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYC));
  assign gap_done    = (cnt_q == CW'(GAP_CYC - 1));

  // First requesting port searching upward from rr_ptr+1, wrapping at N.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(rr_ptr_q) + k) % N;
      if (!found && req[idx]) begin
        winner = PW'(idx);
        found  = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= PW'(N - 1);
      owner_q  <= '0;
      data_q   <= 8'h00;
      baud_q   <= 3'd0;
      lock_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
      baud_q   <= baud_d;
      lock_q   <= lock_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    data_d   = data_q;
    baud_d   = baud_q;
    lock_d   = lock_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: if (|req) begin
        owner_d = winner;
        state_d = S_GRANT;
      end
      S_GRANT: begin
        data_d   = req_data[owner_q*8 +: 8];
        baud_d   = req_baud[owner_q*3 +: 3];
        lock_d   = ~req_last[owner_q];
        rr_ptr_d = owner_q;
        state_d  = S_SETUP;
      end
      S_SETUP: state_d = S_SEND;
      S_SEND: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (timeout_hit) begin
          // An aborted byte breaks the packet; never continue it.
          cnt_d   = '0;
          lock_d  = 1'b0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (gap_done) begin
          cnt_d = '0;
          if (lock_q && req[owner_q]) begin
            state_d = S_GRANT;
          end else begin
            lock_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ack          = '0;
    grant        = '0;
    tx_send_en   = 1'b0;
    err_timeout  = 1'b0;
    tx_data_byte = data_q;
    tx_baud_set  = baud_q;
    busy         = (state_q != S_IDLE);
    if (state_q != S_IDLE) grant[owner_q] = 1'b1;
    if (state_q == S_GRANT) begin
      ack[owner_q] = 1'b1;
      // Present the new baud code during GRANT so it is stable through SETUP.
      tx_baud_set  = req_baud[owner_q*3 +: 3];
    end
    if (state_q == S_SEND) tx_send_en = 1'b1;
    if (state_q == S_WAIT && !tx_done && timeout_hit) err_timeout = 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: per-port byte queues drive the requesters, a
// transmitter model answers send strobes (or stays silent to force timeouts),
// and a reference model predicts the granted port and timing of every byte.
module tb_uart_tx_scheduler;
  localparam int N = 4, GAP = 4, TO = 100;

  logic           Clk = 1'b0;
  logic           Rst_n;
  logic [N-1:0]   req, req_last, ack, grant;
  logic [8*N-1:0] req_data;
  logic [3*N-1:0] req_baud;
  logic [7:0]     tx_data_byte;
  logic [2:0]     tx_baud_set;
  logic           tx_send_en, tx_done, busy, err_timeout;

  uart_tx_scheduler #(.N(N), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .req(req), .req_data(req_data),
    .req_baud(req_baud), .req_last(req_last), .ack(ack), .grant(grant),
    .tx_data_byte(tx_data_byte), .tx_baud_set(tx_baud_set),
    .tx_send_en(tx_send_en), .tx_done(tx_done), .busy(busy),
    .err_timeout(err_timeout));

  always #5 Clk = ~Clk;

  typedef struct packed {logic [7:0] d; logic [2:0] b; logic l;} item_t;
  item_t pq[N][$];

  int    checks = 0, passes = 0, cyc = 0;
  int    m_rr, m_own, last_end, ack_cyc, done_at, spur_at, err_at, pop_port;
  bit    m_lock, force_drop, rand_mode;
  item_t cur;
  int    order[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = N - 1; m_lock = 0; m_own = 0; last_end = -1000; ack_cyc = -1000;
    done_at = -1; spur_at = -1; err_at = -1; pop_port = -1; force_drop = 0;
    for (int i = 0; i < N; i++) pq[i].delete();
    order.delete();
  endtask

  function automatic bit pending();
    pending = 0;
    for (int i = 0; i < N; i++) if (pq[i].size() > 0) pending = 1;
  endfunction

  function automatic int order_code();
    order_code = 0;
    foreach (order[i]) order_code = order_code * 10 + order[i] + 1;
  endfunction

  task automatic push(input int p, input logic [7:0] d, input logic [2:0] b, input logic l);
    item_t it;
    it.d = d; it.b = b; it.l = l;
    pq[p].push_back(it);
  endtask

  // Requesters present their queue head; a port advances one edge after ack.
  task automatic drive_inputs();
    if (pop_port >= 0) begin
      void'(pq[pop_port].pop_front());
      pop_port = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0) begin
        req[i] = 1'b1;
        req_data[8*i +: 8] = pq[i][0].d;
        req_baud[3*i +: 3] = pq[i][0].b;
        req_last[i] = pq[i][0].l;
      end else begin
        req[i] = 1'b0;
      end
    end
    tx_done = (cyc == done_at) || (cyc == spur_at);
  endtask

  task automatic monitor();
    int w;
    if (ack != '0) begin
      chk("ack_onehot", $onehot(ack), 1);
      chk("grant_eq_ack", grant, ack);
      chk("busy_in_grant", busy, 1);
      if (m_lock && pq[m_own].size() > 0) begin
        w = m_own;
        chk("lock_gap_exact", cyc, last_end + 1 + GAP);
      end else begin
        w = -1;
        for (int k = 1; k <= N; k++)
          if (w < 0 && pq[(m_rr + k) % N].size() > 0) w = (m_rr + k) % N;
        chk("gap_min", cyc >= last_end + 2 + GAP, 1);
      end
      chk("ack_port", ack, (w >= 0) ? (1 << w) : 0);
      if (w >= 0) begin
        cur = pq[w][0]; m_rr = w; m_own = w; m_lock = !cur.l; pop_port = w;
        order.push_back(w);
      end
      ack_cyc = cyc;
    end
    if (cyc == ack_cyc + 1) chk("baud_setup", tx_baud_set, cur.b);
    if (tx_send_en || cyc == ack_cyc + 2) begin
      chk("send_en", tx_send_en, cyc == ack_cyc + 2);
      chk("tx_data", tx_data_byte, cur.d);
      chk("tx_baud", tx_baud_set, cur.b);
      if (tx_send_en) begin
        if (force_drop || (rand_mode && $urandom_range(0, 7) == 0)) begin
          err_at = cyc + 1 + TO; done_at = -1; spur_at = -1; force_drop = 0;
        end else begin
          done_at = cyc + int'($urandom_range(1, 6));
          spur_at = (rand_mode && $urandom_range(0, 1) == 1) ? done_at + 2 : -1;
        end
      end
    end
    if (err_timeout || cyc == err_at) begin
      chk("err_timeout", err_timeout, cyc == err_at);
      if (cyc == err_at) begin m_lock = 0; last_end = cyc; end
    end
    if (cyc == done_at) last_end = cyc;
  endtask

  task automatic step();
    @(posedge Clk); #1;
    cyc++;
    drive_inputs();
    #1;
    monitor();
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    do begin step(); n++; end
    while ((pending() || busy || pop_port >= 0 || cyc <= err_at) && n < limit);
    chk(tag, n < limit, 1);
    chk({tag, "_grant_idle"}, grant, 0);
    chk({tag, "_busy_idle"}, busy, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_data"}, tx_data_byte, 0);
    chk({tag, "_baud"}, tx_baud_set, 0);
    chk({tag, "_send"}, tx_send_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_timeout, 0);
  endtask

  initial begin
    Rst_n = 1'b0; req = '0; req_last = '0; req_data = '0; req_baud = '0;
    tx_done = 1'b0; rand_mode = 0;
    model_reset();
    #3;
    chk_reset_outputs("reset");
    repeat (2) @(posedge Clk);
    #2 Rst_n = 1'b1;

    // Round robin among ports 0, 1, 3
    for (int r = 0; r < 2; r++) begin
      push(0, 8'h10 + 8'(r), 3'd1, 1'b1);
      push(1, 8'h20 + 8'(r), 3'd2, 1'b1);
      push(3, 8'h30 + 8'(r), 3'd3, 1'b1);
    end
    drain("rr_drain", 2000);
    chk("rr_order", order_code(), 124124);

    // Single byte on port 2
    order.delete();
    push(2, 8'hA5, 3'd4, 1'b1);
    drain("single_drain", 500);
    chk("single_order", order_code(), 3);

    // Packet lock: port 1 keeps the transmitter for its 3-byte packet
    order.delete();
    push(0, 8'h01, 3'd0, 1'b1);
    drain("pre_lock_drain", 500);
    order.delete();
    push(1, 8'hB0, 3'd5, 1'b0);
    push(1, 8'hB1, 3'd5, 1'b0);
    push(1, 8'hB2, 3'd5, 1'b1);
    push(0, 8'hC0, 3'd6, 1'b1);
    drain("lock_drain", 1000);
    chk("lock_order", order_code(), 2221);

    // Packet abort: port 1 stops after a last=0 byte
    order.delete();
    push(1, 8'hD0, 3'd7, 1'b0);
    push(0, 8'hD1, 3'd2, 1'b1);
    drain("abort_drain", 1000);
    chk("abort_order", order_code(), 21);

    // Timeout on port 3, then port 2 served normally
    order.delete();
    force_drop = 1;
    push(3, 8'hE3, 3'd3, 1'b0);
    drain("timeout_drain", 1000);
    push(2, 8'hE2, 3'd1, 1'b1);
    drain("post_timeout_drain", 500);
    chk("timeout_order", order_code(), 43);

    // Random traffic
    rand_mode = 1;
    for (int p = 0; p < N; p++) begin
      int cnt = int'($urandom_range(0, 6));
      for (int j = 0; j < cnt; j++)
        push(p, 8'($urandom), 3'($urandom), ($urandom_range(0, 2) != 0));
    end
    drain("rand_drain", 20000);
    rand_mode = 0;

    // Reset while waiting for tx_done
    order.delete();
    force_drop = 1;
    push(0, 8'h5A, 3'd6, 1'b1);
    begin
      int n = 0;
      do begin step(); n++; end while (cyc != ack_cyc + 4 && n < 50);
      chk("reach_wait", n < 50, 1);
    end
    chk("wait_data_pre_reset", tx_data_byte, 8'h5A);
    #2 Rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    model_reset();
    repeat (2) @(posedge Clk);
    #2 Rst_n = 1'b1;
    for (int p = 0; p < N; p++) push(p, 8'h60 + 8'(p), 3'(p), 1'b1);
    drain("post_reset_drain", 2000);
    chk("post_reset_order", order_code(), 1234);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
